msrv32_store_unit_mw: RTL and testbench

- Parametrised, sequential data-memory store unit for the msrv32 core.
- Takes a store request from the execute/writeback boundary and drives the data-memory write port with byte-lane data and a write mask.
- Bus width is generic (32 or 64 bits). A req/ack handshake supports memory wait states.
- With MISALIGN_EN=1, a store that crosses a bus word is split into two beats. With MISALIGN_EN=0, it is reported as a fault.

---
 rtl/msrv32_pkg.sv | 22 ++
 rtl/msrv32_store_align.sv | 42 ++++
 rtl/msrv32_store_unit_mw.sv | 165 ++++++++++++++++
 tb/tb_msrv32_store_unit_mw.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 data-memory store path:
// store size encodings, store-unit states and fault causes.
package msrv32_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } store_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10,
    ST_FAULT = 2'b11
  } store_state_e;

  localparam logic CAUSE_MISALIGN = 1'b0;
  localparam logic CAUSE_SIZE     = 1'b1;

endpackage

// File: rtl/msrv32_store_align.sv
// Combinational lane aligner: places the low size bytes of the store data
// at the byte offset across a double-width lane window (beat0 low, beat1 high).
module msrv32_store_align
  import msrv32_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned BUS_B  = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(BUS_B)
) (
  input  logic [1:0]          size_in,
  input  logic [OFF_W-1:0]    off_in,
  input  logic [DATA_W-1:0]   data_in,
  output logic [2*BUS_B-1:0]  wide_mask_out,
  output logic [2*DATA_W-1:0] wide_data_out,
  output logic                split_out,
  output logic                misaligned_out
);

  logic [3:0]        sz_bytes;
  logic [BUS_B-1:0]  lane_mask;
  logic [DATA_W-1:0] lane_data;

  assign sz_bytes = 4'd1 << size_in;

  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    for (int unsigned i = 0; i < BUS_B; i++) begin
      if (i < 32'(sz_bytes)) begin
        lane_mask[i]       = 1'b1;
        lane_data[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  assign wide_mask_out  = {{BUS_B{1'b0}}, lane_mask} << off_in;
  assign wide_data_out  = {{DATA_W{1'b0}}, lane_data} << {off_in, 3'b000};
  assign split_out      = |wide_mask_out[2*BUS_B-1:BUS_B];
  // Natural alignment: offset must be a multiple of the access size.
  assign misaligned_out = (4'(off_in) & (sz_bytes - 4'd1)) != 4'd0;

endmodule

// File: rtl/msrv32_store_unit_mw.sv
// Sequential data-memory store unit: latches a store request, then drives
// one or two registered write beats with req/ack handshaking, or faults.
module msrv32_store_unit_mw
  import msrv32_pkg::*;
#(
  parameter  int unsigned ADDR_W      = 32,
  parameter  int unsigned DATA_W      = 32,
  parameter  bit          MISALIGN_EN = 1'b1,
  localparam int unsigned BUS_B       = DATA_W / 8,
  localparam int unsigned OFF_W       = $clog2(BUS_B)
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_n_in,
  input  logic [1:0]        func3_in,
  input  logic [ADDR_W-1:0] iaddr_in,
  input  logic [DATA_W-1:0] rs2_in,
  input  logic              mem_wr_req_in,
  input  logic              ms_riscv32_mp_dmwr_ack_in,
  output logic [ADDR_W-1:0] ms_riscv32_mp_dmaddr_out,
  output logic [DATA_W-1:0] ms_riscv32_mp_dmdata_out,
  output logic [BUS_B-1:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic              ms_riscv32_mp_dmwr_req_out,
  output logic              store_busy_out,
  output logic              store_done_out,
  output logic              store_fault_out,
  output logic              fault_cause_out
);

  store_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] hi_data_q, hi_data_d;
  logic [BUS_B-1:0]  hi_mask_q, hi_mask_d;
  logic              split_q, split_d;
  logic [ADDR_W-1:0] dmaddr_q, dmaddr_d;
  logic [DATA_W-1:0] dmdata_q, dmdata_d;
  logic [BUS_B-1:0]  mask_q, mask_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              cause_q, cause_d;

  logic [2*BUS_B-1:0]  wide_mask;
  logic [2*DATA_W-1:0] wide_data;
  logic                split;
  logic                misaligned;
  logic                illegal_size;
  logic [ADDR_W-1:0]   aligned_addr;

  msrv32_store_align #(.DATA_W(DATA_W)) u_align (
    .size_in        (func3_in),
    .off_in         (iaddr_in[OFF_W-1:0]),
    .data_in        (rs2_in),
    .wide_mask_out  (wide_mask),
    .wide_data_out  (wide_data),
    .split_out      (split),
    .misaligned_out (misaligned)
  );

  assign illegal_size = (DATA_W == 32) && (store_size_e'(func3_in) == SZ_D);
  assign aligned_addr = {iaddr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    hi_data_d = hi_data_q;
    hi_mask_d = hi_mask_q;
    split_d   = split_q;
    dmaddr_d  = dmaddr_q;
    dmdata_d  = dmdata_q;
    mask_d    = mask_q;
    req_d     = req_q;
    done_d    = 1'b0;
    fault_d   = 1'b0;
    cause_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_wr_req_in) begin
          if (illegal_size) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_SIZE;
          end else if (!MISALIGN_EN && misaligned) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            // Both beats are computed at accept; beat1 is parked until beat0 is acked.
            state_d   = ST_BEAT0;
            base_d    = aligned_addr;
            dmaddr_d  = aligned_addr;
            dmdata_d  = wide_data[DATA_W-1:0];
            mask_d    = wide_mask[BUS_B-1:0];
            hi_data_d = wide_data[2*DATA_W-1:DATA_W];
            hi_mask_d = wide_mask[2*BUS_B-1:BUS_B];
            split_d   = split;
            req_d     = 1'b1;
          end
        end
      end
      ST_BEAT0: begin
        if (ms_riscv32_mp_dmwr_ack_in) begin
          if (split_q) begin
            state_d  = ST_BEAT1;
            dmaddr_d = base_q + ADDR_W'(BUS_B);
            dmdata_d = hi_data_q;
            mask_d   = hi_mask_q;
          end else begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        if (ms_riscv32_mp_dmwr_ack_in) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      hi_data_q <= '0;
      hi_mask_q <= '0;
      split_q   <= 1'b0;
      dmaddr_q  <= '0;
      dmdata_q  <= '0;
      mask_q    <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      hi_data_q <= hi_data_d;
      hi_mask_q <= hi_mask_d;
      split_q   <= split_d;
      dmaddr_q  <= dmaddr_d;
      dmdata_q  <= dmdata_d;
      mask_q    <= mask_d;
      req_q     <= req_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
    end
  end

  assign ms_riscv32_mp_dmaddr_out    = dmaddr_q;
  assign ms_riscv32_mp_dmdata_out    = dmdata_q;
  assign ms_riscv32_mp_dmwr_mask_out = mask_q;
  assign ms_riscv32_mp_dmwr_req_out  = req_q;
  assign store_busy_out              = (state_q != ST_IDLE);
  assign store_done_out              = done_q;
  assign store_fault_out             = fault_q;
  assign fault_cause_out             = cause_q;

endmodule

// File: tb/tb_msrv32_store_unit_mw.sv
// Bench for msrv32_store_unit_mw: 32-bit split-capable, 32-bit fault-on-misalign
// and 64-bit instances, with a beat scoreboard on the 32-bit split-capable unit.
module tb_msrv32_store_unit_mw;

  logic clk;
  logic rst_n;

  // 32-bit, MISALIGN_EN=1
  logic [1:0]  a_f3;
  logic [31:0] a_addr, a_data, a_dmaddr, a_dmdata;
  logic        a_req, a_ack, a_wreq, a_busy, a_done, a_fault, a_cause;
  logic [3:0]  a_mask;
  // 32-bit, MISALIGN_EN=0
  logic [1:0]  f_f3;
  logic [31:0] f_addr, f_data, f_dmaddr, f_dmdata;
  logic        f_req, f_ack, f_wreq, f_busy, f_done, f_fault, f_cause;
  logic [3:0]  f_mask;
  // 64-bit, MISALIGN_EN=1
  logic [1:0]  w_f3;
  logic [31:0] w_addr, w_dmaddr;
  logic [63:0] w_data, w_dmdata;
  logic        w_req, w_ack, w_wreq, w_busy, w_done, w_fault, w_cause;
  logic [7:0]  w_mask;

  msrv32_store_unit_mw #(.ADDR_W(32), .DATA_W(32), .MISALIGN_EN(1'b1)) u_a (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .func3_in(a_f3), .iaddr_in(a_addr), .rs2_in(a_data), .mem_wr_req_in(a_req),
    .ms_riscv32_mp_dmwr_ack_in(a_ack), .ms_riscv32_mp_dmaddr_out(a_dmaddr),
    .ms_riscv32_mp_dmdata_out(a_dmdata), .ms_riscv32_mp_dmwr_mask_out(a_mask),
    .ms_riscv32_mp_dmwr_req_out(a_wreq), .store_busy_out(a_busy),
    .store_done_out(a_done), .store_fault_out(a_fault), .fault_cause_out(a_cause));

  msrv32_store_unit_mw #(.ADDR_W(32), .DATA_W(32), .MISALIGN_EN(1'b0)) u_f (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .func3_in(f_f3), .iaddr_in(f_addr), .rs2_in(f_data), .mem_wr_req_in(f_req),
    .ms_riscv32_mp_dmwr_ack_in(f_ack), .ms_riscv32_mp_dmaddr_out(f_dmaddr),
    .ms_riscv32_mp_dmdata_out(f_dmdata), .ms_riscv32_mp_dmwr_mask_out(f_mask),
    .ms_riscv32_mp_dmwr_req_out(f_wreq), .store_busy_out(f_busy),
    .store_done_out(f_done), .store_fault_out(f_fault), .fault_cause_out(f_cause));

  msrv32_store_unit_mw #(.ADDR_W(32), .DATA_W(64), .MISALIGN_EN(1'b1)) u_w (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .func3_in(w_f3), .iaddr_in(w_addr), .rs2_in(w_data), .mem_wr_req_in(w_req),
    .ms_riscv32_mp_dmwr_ack_in(w_ack), .ms_riscv32_mp_dmaddr_out(w_dmaddr),
    .ms_riscv32_mp_dmdata_out(w_dmdata), .ms_riscv32_mp_dmwr_mask_out(w_mask),
    .ms_riscv32_mp_dmwr_req_out(w_wreq), .store_busy_out(w_busy),
    .store_done_out(w_done), .store_fault_out(w_fault), .fault_cause_out(w_cause));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } beat_t;

  typedef struct {
    logic [1:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned wt;
    logic        split;
    beat_t       b0;
    beat_t       b1;
  } vec_t;

  beat_t sb_q[$];
  vec_t  vecs[9];

  // Every cycle the 32-bit unit requests, compare against the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && a_wreq) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", 64'(a_wreq), 64'd0);
      end else begin
        chk("beat_addr", 64'(a_dmaddr), 64'(sb_q[0].addr));
        chk("beat_data", 64'(a_dmdata), 64'(sb_q[0].data));
        chk("beat_mask", 64'(a_mask), 64'(sb_q[0].mask));
        if (a_ack) void'(sb_q.pop_front());
      end
    end
  end

  task automatic run32(input vec_t v);
    int unsigned nb;
    @(posedge clk); #1;
    a_f3 = v.f3; a_addr = v.addr; a_data = v.data; a_req = 1'b1;
    sb_q.push_back(v.b0);
    if (v.split) sb_q.push_back(v.b1);
    @(posedge clk); #1;
    a_req = 1'b0; a_addr = $urandom; a_data = $urandom;
    nb = v.split ? 2 : 1;
    for (int unsigned b = 0; b < nb; b++) begin
      chk("req_high", 64'(a_wreq), 64'd1);
      chk("busy_high", 64'(a_busy), 64'd1);
      chk("no_early_done", 64'(a_done), 64'd0);
      repeat (v.wt) begin
        @(posedge clk); #1;
        chk("req_hold", 64'(a_wreq), 64'd1);
        chk("busy_hold", 64'(a_busy), 64'd1);
      end
      a_ack = 1'b1;
      @(posedge clk); #1;
      a_ack = 1'b0;
    end
    chk("done", 64'(a_done), 64'd1);
    chk("busy_idle", 64'(a_busy), 64'd0);
    chk("req_low", 64'(a_wreq), 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
    chk("done_pulse", 64'(a_done), 64'd0);
  endtask

  task automatic fault32(input logic [1:0] f3, input logic [31:0] addr, input logic cause);
    @(posedge clk); #1;
    f_f3 = f3; f_addr = addr; f_data = 32'h1122_3344; f_req = 1'b1;
    @(posedge clk); #1;
    f_req = 1'b0;
    chk("fault", 64'(f_fault), 64'd1);
    chk("fault_cause", 64'(f_cause), 64'(cause));
    chk("fault_no_req", 64'(f_wreq), 64'd0);
    chk("fault_busy", 64'(f_busy), 64'd1);
    @(posedge clk); #1;
    chk("fault_pulse", 64'(f_fault), 64'd0);
    chk("fault_no_req2", 64'(f_wreq), 64'd0);
    chk("fault_no_done", 64'(f_done), 64'd0);
    chk("fault_idle", 64'(f_busy), 64'd0);
  endtask

  task automatic beat64(input logic [31:0] ea, input logic [63:0] ed, input logic [7:0] em);
    chk("w_req", 64'(w_wreq), 64'd1);
    chk("w_addr", 64'(w_dmaddr), 64'(ea));
    chk("w_data", w_dmdata, ed);
    chk("w_mask", 64'(w_mask), 64'(em));
    w_ack = 1'b1;
    @(posedge clk); #1;
    w_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_f3 = '0; a_addr = '0; a_data = '0; a_req = 1'b0; a_ack = 1'b0;
    f_f3 = '0; f_addr = '0; f_data = '0; f_req = 1'b0; f_ack = 1'b0;
    w_f3 = '0; w_addr = '0; w_data = '0; w_req = 1'b0; w_ack = 1'b0;

    vecs[0] = '{2'b00, 32'h0000_1003, 32'h0000_00A5, 0, 1'b0,
                '{32'h0000_1000, 32'hA500_0000, 4'b1000}, '{32'h0, 32'h0, 4'h0}};
    vecs[1] = '{2'b10, 32'h0000_2002, 32'h1122_3344, 0, 1'b1,
                '{32'h0000_2000, 32'h3344_0000, 4'b1100}, '{32'h0000_2004, 32'h0000_1122, 4'b0011}};
    vecs[2] = '{2'b01, 32'h0000_3003, 32'h0000_BEEF, 3, 1'b1,
                '{32'h0000_3000, 32'hEF00_0000, 4'b1000}, '{32'h0000_3004, 32'h0000_00BE, 4'b0001}};
    vecs[3] = '{2'b10, 32'h0000_4000, 32'hDEAD_BEEF, 1, 1'b0,
                '{32'h0000_4000, 32'hDEAD_BEEF, 4'b1111}, '{32'h0, 32'h0, 4'h0}};
    vecs[4] = '{2'b01, 32'h0000_5001, 32'h0000_1234, 0, 1'b0,
                '{32'h0000_5000, 32'h0012_3400, 4'b0110}, '{32'h0, 32'h0, 4'h0}};
    vecs[5] = '{2'b00, 32'h0000_6000, 32'hFFFF_FF77, 0, 1'b0,
                '{32'h0000_6000, 32'h0000_0077, 4'b0001}, '{32'h0, 32'h0, 4'h0}};
    vecs[6] = '{2'b01, 32'h0000_7002, 32'hAAAA_5566, 2, 1'b0,
                '{32'h0000_7000, 32'h5566_0000, 4'b1100}, '{32'h0, 32'h0, 4'h0}};
    vecs[7] = '{2'b10, 32'hFFFF_FFFD, 32'hCAFE_BABE, 2, 1'b1,
                '{32'hFFFF_FFFC, 32'hFEBA_BE00, 4'b1110}, '{32'h0000_0000, 32'h0000_00CA, 4'b0001}};
    vecs[8] = '{2'b01, 32'h0000_0100, 32'h1234_5678, 0, 1'b0,
                '{32'h0000_0100, 32'h0000_5678, 4'b0011}, '{32'h0, 32'h0, 4'h0}};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 64'(a_dmaddr), 64'd0);
    chk("rst_data", 64'(a_dmdata), 64'd0);
    chk("rst_mask", 64'(a_mask), 64'd0);
    chk("rst_req", 64'(a_wreq), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_fault", 64'(a_fault), 64'd0);
    chk("rst_cause", 64'(a_cause), 64'd0);
    chk("rst_w_mask", 64'(w_mask), 64'd0);
    chk("rst_f_busy", 64'(f_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ack while idle must not start anything.
    @(posedge clk); #1;
    a_ack = 1'b1;
    @(posedge clk); #1;
    a_ack = 1'b0;
    chk("idle_ack_req", 64'(a_wreq), 64'd0);
    chk("idle_ack_done", 64'(a_done), 64'd0);

    for (int i = 0; i < 9; i++) run32(vecs[i]);

    // Reset during beat1 of a split store.
    @(posedge clk); #1;
    a_f3 = 2'b10; a_addr = 32'h0000_2002; a_data = 32'h1122_3344; a_req = 1'b1;
    sb_q.push_back(vecs[1].b0);
    sb_q.push_back(vecs[1].b1);
    @(posedge clk); #1;
    a_req = 1'b0; a_ack = 1'b1;
    @(posedge clk); #1;
    a_ack = 1'b0;
    chk("b1_req", 64'(a_wreq), 64'd1);
    chk("b1_mask", 64'(a_mask), 64'(4'b0011));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req", 64'(a_wreq), 64'd0);
    chk("async_mask", 64'(a_mask), 64'd0);
    chk("async_busy", 64'(a_busy), 64'd0);
    sb_q.delete();
    a_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_ack = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", 64'(a_done), 64'd0);
      chk("post_rst_no_req", 64'(a_wreq), 64'd0);
    end
    run32(vecs[0]);

    // Fault-on-misalign unit.
    fault32(2'b10, 32'h0000_2002, 1'b0);
    fault32(2'b01, 32'h0000_2001, 1'b0);
    fault32(2'b11, 32'h0000_0100, 1'b1);
    @(posedge clk); #1;
    f_f3 = 2'b10; f_addr = 32'h0000_2004; f_data = 32'h1122_3344; f_req = 1'b1;
    @(posedge clk); #1;
    f_req = 1'b0;
    chk("f_aligned_req", 64'(f_wreq), 64'd1);
    chk("f_aligned_addr", 64'(f_dmaddr), 64'h2004);
    chk("f_aligned_data", 64'(f_dmdata), 64'h1122_3344);
    chk("f_aligned_mask", 64'(f_mask), 64'hF);
    chk("f_aligned_nofault", 64'(f_fault), 64'd0);
    f_ack = 1'b1;
    @(posedge clk); #1;
    f_ack = 1'b0;
    chk("f_aligned_done", 64'(f_done), 64'd1);

    // 64-bit unit: SD aligned, SW upper half, SD split across words.
    @(posedge clk); #1;
    w_f3 = 2'b11; w_addr = 32'h8; w_data = 64'h0123_4567_89AB_CDEF; w_req = 1'b1;
    @(posedge clk); #1;
    w_req = 1'b0;
    beat64(32'h8, 64'h0123_4567_89AB_CDEF, 8'hFF);
    chk("w_sd_done", 64'(w_done), 64'd1);
    @(posedge clk); #1;
    w_f3 = 2'b10; w_addr = 32'h4; w_req = 1'b1;
    @(posedge clk); #1;
    w_req = 1'b0;
    beat64(32'h0, 64'h89AB_CDEF_0000_0000, 8'hF0);
    chk("w_sw_done", 64'(w_done), 64'd1);
    @(posedge clk); #1;
    w_f3 = 2'b11; w_addr = 32'hC; w_req = 1'b1;
    @(posedge clk); #1;
    w_req = 1'b0;
    beat64(32'h8, 64'h89AB_CDEF_0000_0000, 8'hF0);
    chk("w_split_no_done", 64'(w_done), 64'd0);
    beat64(32'h10, 64'h0000_0000_0123_4567, 8'h0F);
    chk("w_split_done", 64'(w_done), 64'd1);
    chk("w_fault_never", 64'(w_fault), 64'd0);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
